// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH chained skid-buffer stages under valid/ready.
// Optional occupancy counter enabled by defining PIPE_REG_OCC_EN.
module pipe_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Link i is the input side of stage i; link DEPTH is the pipe output.
  logic [DEPTH:0]   valid_link;
  logic [DEPTH:0]   ready_link;
  logic [WIDTH-1:0] data_link [DEPTH+1];

  assign valid_link[0]     = in_valid;
  assign data_link[0]      = in_data;
  assign ready_link[DEPTH] = out_ready;
  assign in_ready          = ready_link[0];
  assign out_valid         = valid_link[DEPTH];
  assign out_data          = data_link[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    stage_state_t     state;
    stage_state_t     state_next;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    always_comb begin
      in_fire        = valid_link[i] && ready_q;
      out_fire       = (state != EMPTY) && ready_link[i+1];
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
        state_next = EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state_next   = BUSY;
              load_main_in = 1'b1;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              load_main_in = 1'b1;
            end else if (in_fire) begin
              state_next = FULL;
              load_skid  = 1'b1;
            end else if (out_fire) begin
              state_next = EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              state_next     = BUSY;
              load_main_skid = 1'b1;
            end
          end
          default: state_next = EMPTY;
        endcase
      end
    end

    // Ready is registered from the next state so no ready path crosses stages.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= EMPTY;
        main_data <= '0;
        skid_data <= '0;
        ready_q   <= 1'b0;
      end else begin
        state   <= state_next;
        ready_q <= (state_next != FULL);
        if (load_main_in)
          main_data <= data_link[i];
        else if (load_main_skid)
          main_data <= skid_data;
        if (load_skid)
          skid_data <= data_link[i];
      end
    end

    assign valid_link[i+1] = (state != EMPTY);
    assign data_link[i+1]  = main_data;
    assign ready_link[i]   = ready_q;
  end

`ifdef PIPE_REG_OCC_EN
  logic             pipe_in_fire;
  logic             pipe_out_fire;
  logic [OCC_W-1:0] occ_q;

  assign pipe_in_fire  = in_valid && in_ready;
  assign pipe_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (pipe_in_fire && !pipe_out_fire) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (pipe_out_fire && !pipe_in_fire) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign occupancy = occ_q;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg: a WIDTH=16/DEPTH=2 instance with a
// queue scoreboard plus a WIDTH=1/DEPTH=1 corner instance.
module tb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  occupancy;

  logic        s_flush;
  logic        s_in_valid;
  logic [0:0]  s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [0:0]  s_out_data;
  logic        s_out_ready;
  logic [1:0]  s_occupancy;

  int          compare_count = 0;
  int          mismatch_count = 0;
  int          occ_model = 0;
  logic [15:0] sb [$];
  logic [0:0]  s_sb [$];

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  pipe_reg #(.WIDTH(1), .DEPTH(1)) dut_small (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .occupancy(s_occupancy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] exp_occ(input int words);
`ifdef PIPE_REG_OCC_EN
    return 32'(words);
`else
    return 32'(words * 0);
`endif
  endfunction

  // One clock on the main instance, updating the scoreboard from pre-edge handshakes.
  task automatic cycle();
    logic in_fire;
    logic out_fire;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire)
      checkOutput("sb_order", 32'(out_data), (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD_BEEF);
    if (flush) begin
      sb.delete();
      occ_model = 0;
    end else begin
      if (in_fire) sb.push_back(in_data);
      if (in_fire && !out_fire) occ_model++;
      if (out_fire && !in_fire) occ_model--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    cycle();
  endtask

  task automatic s_cycle();
    logic in_fire;
    logic out_fire;
    in_fire  = s_in_valid && s_in_ready;
    out_fire = s_out_valid && s_out_ready;
    if (out_fire)
      checkOutput("small_order", 32'(s_out_data), (s_sb.size() > 0) ? 32'(s_sb.pop_front()) : 32'hDEAD_BEEF);
    if (in_fire) s_sb.push_back(s_in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    int sent;
    int budget;
    logic stalled;
    logic [15:0] held;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

    // Power-on reset
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    checkOutput("release_in_ready", 32'(in_ready), 1);
    checkOutput("release_occ", 32'(occupancy), exp_occ(0));

    // Streaming with latency of DEPTH edges and full throughput
    for (int i = 1; i <= 16; i++) begin
      checkOutput("stream_ready", 32'(in_ready), 1);
      applyStimulus(1'b1, 16'(i), 1'b1);
      if (i == 1) checkOutput("latency_not_yet", 32'(out_valid), 0);
      if (i == 2) begin
        checkOutput("latency_valid", 32'(out_valid), 1);
        checkOutput("latency_data", 32'(out_data), 32'h0001);
      end
      if (i > 2) checkOutput("stream_valid", 32'(out_valid), 1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("stream_drained", 32'(sb.size()), 0);
    checkOutput("stream_empty", 32'(out_valid), 0);

    // Fill against a stall: exactly 2*DEPTH words
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) accepted++;
      applyStimulus(1'b1, 16'h0100 + 16'(accepted), 1'b0);
    end
    checkOutput("fill_count", 32'(accepted), 4);
    checkOutput("fill_ready_low", 32'(in_ready), 0);
    checkOutput("fill_occ", 32'(occupancy), exp_occ(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_no_gap", 32'(out_valid), 1);
      applyStimulus(1'b0, 16'h0, 1'b1);
    end
    checkOutput("drain_done", 32'(out_valid), 0);
    checkOutput("drain_sb", 32'(sb.size()), 0);

    // Flush with three words held and a fourth offered
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b0);
    in_valid = 1'b1; in_data = 16'hBAD1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_valid", 32'(out_valid), 0);
    checkOutput("flush_occ", 32'(occupancy), exp_occ(0));
    checkOutput("flush_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("flush_no_word", 32'(out_valid), 0);
    end

    // Random traffic under random backpressure
    sent = 0;
    budget = 0;
    in_valid = 1'b0;
    while (sent < 1000 && budget < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      stalled = out_valid && !out_ready;
      held = (sb.size() > 0) ? sb[0] : 16'h0;
      if (in_valid && in_ready) begin
        sent++;
        cycle();
        in_valid = 1'b0;
      end else begin
        cycle();
      end
      if (stalled) begin
        checkOutput("hold_valid", 32'(out_valid), 1);
        checkOutput("hold_data", 32'(out_data), 32'(held));
      end
      checkOutput("random_occ", 32'(occupancy), exp_occ(occ_model));
      budget++;
    end
    checkOutput("random_sent", 32'(sent), 1000);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("random_drained", 32'(sb.size()), 0);

    // Asynchronous reset with three words held
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'hA5A1 + 16'(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 0);
    checkOutput("midreset_out_data", 32'(out_data), 0);
    checkOutput("midreset_in_ready", 32'(in_ready), 0);
    sb.delete();
    occ_model = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    checkOutput("midreset_release_ready", 32'(in_ready), 1);
    checkOutput("midreset_release_occ", 32'(occupancy), exp_occ(0));
    checkOutput("midreset_release_valid", 32'(out_valid), 0);

    // DEPTH=1 WIDTH=1 corner: capacity 2, latency 1, alternating backpressure
    accepted = 0;
    s_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s_in_ready) accepted++;
      s_in_valid = 1'b1;
      s_in_data  = 1'(accepted);
      s_cycle();
    end
    checkOutput("small_capacity", 32'(accepted), 2);
    checkOutput("small_ready_low", 32'(s_in_ready), 0);
    checkOutput("small_occ", 32'(s_occupancy), exp_occ(2));
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) s_cycle();
    checkOutput("small_drained", 32'(s_sb.size()), 0);
    s_in_valid = 1'b1; s_in_data = 1'b1;
    s_cycle();
    s_in_valid = 1'b0;
    checkOutput("small_latency_valid", 32'(s_out_valid), 1);
    checkOutput("small_latency_data", 32'(s_out_data), 1);
    s_cycle();
    sent = 0;
    for (int i = 0; i < 60 && sent < 20; i++) begin
      if (!s_in_valid) begin
        s_in_valid = 1'b1;
        s_in_data  = 1'(sent[0] ^ sent[2]);
      end
      s_out_ready = 1'(i[0]);
      if (s_in_valid && s_in_ready) begin
        sent++;
        s_cycle();
        s_in_valid = 1'b0;
      end else begin
        s_cycle();
      end
    end
    checkOutput("small_sent", 32'(sent), 20);
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) s_cycle();
    checkOutput("small_final_drain", 32'(s_sb.size()), 0);
    checkOutput("small_final_valid", 32'(s_out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
